// File: rtl/tacho_multi_defs.sv
// rtl/tacho_multi_defs.sv - register map and shared constants for tacho_multi
package tacho_multi_defs;

    localparam int CNT_WIDTH = 16;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_STATUS   = 5'd1;
    localparam logic [4:0] REG_IRQ_EN   = 5'd2;
    localparam logic [4:0] REG_CNT_BASE = 5'd3;

    // Each channel owns a HI/LO byte pair starting at REG_CNT_BASE.
    function automatic logic [4:0] cnt_hi_off(input int ch);
        return 5'(int'(REG_CNT_BASE) + 2 * ch);
    endfunction

    function automatic logic [4:0] cnt_lo_off(input int ch);
        return 5'(int'(REG_CNT_BASE) + 2 * ch + 1);
    endfunction

endpackage

// File: rtl/tacho_channel.sv
// rtl/tacho_channel.sv - one tach input: sync, glitch filter, edge count, gate latch, stall
module tacho_channel
    import tacho_multi_defs::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 ce_i,
    input  logic                 tacho_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 stall_set_o
);

    localparam int RUN_W = $clog2(FILTER_LEN);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_q;
    logic                 level_d;
    logic [RUN_W-1:0]     run_q;
    logic [RUN_W-1:0]     run_d;
    logic [CNT_WIDTH-1:0] run_cnt_q;
    logic [CNT_WIDTH-1:0] run_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 differ;
    logic                 accept;
    logic                 edge_w;

    // Filter accepts a new level on the FILTER_LEN-th consecutive differing sample;
    // the rising acceptance itself is the edge pulse, so no extra register stage.
    always_comb begin
        differ    = sync2_q ^ level_q;
        accept    = differ && (run_q == RUN_W'(FILTER_LEN - 1));
        run_d     = (differ && !accept) ? run_q + 1'b1 : '0;
        level_d   = accept ? sync2_q : level_q;
        edge_w    = accept & sync2_q;

        run_cnt_d = run_cnt_q;
        if (!en_i) begin
            run_cnt_d = '0;
        end else if (ce_i) begin
            // An edge in the gate cycle belongs to the new gate.
            run_cnt_d = {{(CNT_WIDTH-1){1'b0}}, edge_w};
        end else if (edge_w && (run_cnt_q != '1)) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        cnt_d       = ce_i ? run_cnt_q : cnt_q;
        stall_set_o = ce_i & en_i & (run_cnt_q == '0);
    end

    // Synchroniser, filter, running and latched counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            run_q     <= '0;
            run_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= tacho_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            run_q     <= run_d;
            run_cnt_q <= run_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tacho_multi.sv
// rtl/tacho_multi.sv - multi-channel fan tachometer with CSR window and stall interrupt
module tacho_multi
    import tacho_multi_defs::*;
#(
    parameter logic [4:0] BASE_ADDR    = 5'h0,
    parameter int         NUM_CHANNELS = 2,
    parameter int         FILTER_LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              csr_a,
    input  logic [7:0]              csr_di,
    input  logic                    csr_we,
    output logic [7:0]              csr_do,
    input  logic                    ce_1hz,
    input  logic [NUM_CHANNELS-1:0] tacho_in,
    output logic                    irq
);

    localparam logic [4:0] WIN_SIZE = 5'(3 + 2 * NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0] ctrl_q;
    logic [NUM_CHANNELS-1:0] ctrl_d;
    logic [NUM_CHANNELS-1:0] status_q;
    logic [NUM_CHANNELS-1:0] status_d;
    logic [NUM_CHANNELS-1:0] irq_en_q;
    logic [NUM_CHANNELS-1:0] irq_en_d;
    logic                    irq_q;
    logic                    irq_d;
    logic [NUM_CHANNELS-1:0] stall_set_w;
    logic [CNT_WIDTH-1:0]    cnt_w [NUM_CHANNELS];
    logic [4:0]              off;
    logic                    in_win;
    logic                    unused_di;

    assign off       = csr_a - BASE_ADDR;
    assign in_win    = off < WIN_SIZE;
    assign unused_di = ^csr_di[7:NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        tacho_channel #(
            .FILTER_LEN(FILTER_LEN)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en_i       (ctrl_q[i]),
            .ce_i       (ce_1hz),
            .tacho_i    (tacho_in[i]),
            .cnt_o      (cnt_w[i]),
            .stall_set_o(stall_set_w[i])
        );
    end

    // Register write decode; a stall set in the same cycle overrides the W1C clear.
    always_comb begin
        ctrl_d   = ctrl_q;
        irq_en_d = irq_en_q;
        status_d = status_q;
        if (csr_we && in_win && (off == REG_CTRL)) begin
            ctrl_d = csr_di[NUM_CHANNELS-1:0];
        end
        if (csr_we && in_win && (off == REG_IRQ_EN)) begin
            irq_en_d = csr_di[NUM_CHANNELS-1:0];
        end
        if (csr_we && in_win && (off == REG_STATUS)) begin
            status_d = status_q & ~csr_di[NUM_CHANNELS-1:0];
        end
        status_d = status_d | stall_set_w;
        irq_d    = |(status_q & irq_en_q);
    end

    // CSR state and the registered interrupt line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational read mux; anything outside the window reads zero.
    always_comb begin
        csr_do = 8'h00;
        if (in_win) begin
            if (off == REG_CTRL)   csr_do[NUM_CHANNELS-1:0] = ctrl_q;
            if (off == REG_STATUS) csr_do[NUM_CHANNELS-1:0] = status_q;
            if (off == REG_IRQ_EN) csr_do[NUM_CHANNELS-1:0] = irq_en_q;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (off == cnt_hi_off(i)) csr_do = cnt_w[i][15:8];
                if (off == cnt_lo_off(i)) csr_do = cnt_w[i][7:0];
            end
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_tacho_multi.sv
// tb/tb_tacho_multi.sv - directed self-checking bench for tacho_multi
`timescale 1ns/100ps
module tb_tacho_multi;

    localparam int         NCH  = 2;
    localparam int         FL   = 4;
    localparam logic [4:0] BASE = 5'h0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4:0]     csr_a = 5'd0;
    logic [7:0]     csr_di = 8'd0;
    logic           csr_we = 1'b0;
    logic [7:0]     csr_do;
    logic           ce_1hz = 1'b0;
    logic [NCH-1:0] tacho_in = '0;
    logic           irq;

    int vectors     = 0;
    int miscompares = 0;

    tacho_multi #(
        .BASE_ADDR   (BASE),
        .NUM_CHANNELS(NCH),
        .FILTER_LEN  (FL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .csr_a   (csr_a),
        .csr_di  (csr_di),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .ce_1hz  (ce_1hz),
        .tacho_in(tacho_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = BASE + a;
        csr_di = d;
        csr_we = 1'b1;
        tick(1);
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        csr_a = BASE + a;
        #1;
        check(tag, {24'd0, csr_do}, {24'd0, exp});
    endtask

    task automatic gate();
        ce_1hz = 1'b1;
        tick(1);
        ce_1hz = 1'b0;
    endtask

    task automatic pulses(input int ch, input int n, input int hi, input int lo);
        repeat (n) begin
            tacho_in[ch] = 1'b1;
            tick(hi);
            tacho_in[ch] = 1'b0;
            tick(lo);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        rd_chk("rst_ctrl",   5'd0, 8'h00);
        rd_chk("rst_status", 5'd1, 8'h00);
        rd_chk("rst_irqen",  5'd2, 8'h00);
        rd_chk("rst_cnt0hi", 5'd3, 8'h00);
        rd_chk("rst_cnt0lo", 5'd4, 8'h00);
        rd_chk("rst_cnt1lo", 5'd6, 8'h00);
        rd_chk("rst_oow",    5'd7, 8'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);

        wr(5'd0, 8'hFF);
        rd_chk("ctrl_mask", 5'd0, 8'h03);
        wr(5'd2, 8'hFC);
        rd_chk("irqen_mask", 5'd2, 8'h00);
        wr(5'd3, 8'h55);
        rd_chk("cnt_ro", 5'd3, 8'h00);

        gate();
        rd_chk("first_gate_stall", 5'd1, 8'h03);
        wr(5'd1, 8'h03);
        rd_chk("w1c_clear", 5'd1, 8'h00);

        pulses(0, 120, 5, 5);
        tick(8);
        rd_chk("cnt_stable_pre_gate", 5'd4, 8'h00);
        gate();
        rd_chk("cnt120_hi", 5'd3, 8'h00);
        rd_chk("cnt120_lo", 5'd4, 8'h78);
        rd_chk("idle_ch1_stall", 5'd1, 8'h02);
        rd_chk("idle_ch1_cnt", 5'd6, 8'h00);
        wr(5'd1, 8'h03);

        pulses(0, 1, 1, 8);
        pulses(0, 2, FL - 1, 8);
        tick(4);
        gate();
        rd_chk("glitch_rejected", 5'd4, 8'h00);
        pulses(0, 3, FL, 6);
        tick(8);
        gate();
        rd_chk("filterlen_counted", 5'd4, 8'h03);

        force dut.g_ch[0].u_ch.run_cnt_q = 16'hFFFD;
        tick(1);
        release dut.g_ch[0].u_ch.run_cnt_q;
        pulses(0, 5, 5, 5);
        tick(8);
        gate();
        rd_chk("sat_hi", 5'd3, 8'hFF);
        rd_chk("sat_lo", 5'd4, 8'hFF);

        tacho_in[0] = 1'b1;
        tick(5);
        ce_1hz = 1'b1;
        tick(1);
        ce_1hz = 1'b0;
        rd_chk("coinc_edge_excluded", 5'd4, 8'h00);
        tick(3);
        tacho_in[0] = 1'b0;
        tick(10);
        gate();
        rd_chk("coinc_edge_reload1", 5'd4, 8'h01);

        wr(5'd1, 8'h03);
        rd_chk("pre_race_clear", 5'd1, 8'h00);
        csr_a  = BASE + 5'd1;
        csr_di = 8'h02;
        csr_we = 1'b1;
        ce_1hz = 1'b1;
        tick(1);
        csr_we = 1'b0;
        ce_1hz = 1'b0;
        rd_chk("set_wins_w1c", 5'd1, 8'h03);

        wr(5'd1, 8'h03);
        wr(5'd2, 8'h02);
        rd_chk("irqen_rw", 5'd2, 8'h02);
        check("irq_idle", {31'd0, irq}, 32'd0);
        gate();
        rd_chk("irq_stall_status", 5'd1, 8'h03);
        check("irq_lag", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_set", {31'd0, irq}, 32'd1);
        wr(5'd1, 8'h02);
        tick(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("status_after_w1c", 5'd1, 8'h01);
        wr(5'd2, 8'h00);
        gate();
        tick(2);
        check("irq_masked", {31'd0, irq}, 32'd0);

        wr(5'd1, 8'h03);
        wr(5'd2, 8'h02);
        pulses(0, 5, 5, 5);
        tick(8);
        gate();
        tick(1);
        rd_chk("pre_rst_cnt", 5'd4, 8'h05);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        pulses(0, 3, 5, 5);
        rst = 1'b1;
        #1;
        rd_chk("midrst_ctrl",   5'd0, 8'h00);
        rd_chk("midrst_status", 5'd1, 8'h00);
        rd_chk("midrst_irqen",  5'd2, 8'h00);
        rd_chk("midrst_cnt0lo", 5'd4, 8'h00);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        wr(5'd0, 8'h03);
        pulses(0, 2, 5, 5);
        tick(8);
        gate();
        rd_chk("partial_after_rst", 5'd4, 8'h02);
        rd_chk("oow_after", 5'(3 + 2 * NCH), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
